soc_apb_timer_ctrl: RTL

SOC_APB_TIMER_CTRL -- requirements
Module: soc_apb_timer_ctrl

---
 rtl/soc_apb_timer_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/soc_apb_timer_ctrl.sv
// Timer control FSM: sequences an external 32-bit counter through IDLE/RUN/DONE,
// with an optional prescaler, continuous or one-shot mode, and a sticky interrupt.
module soc_apb_timer_ctrl #(
    parameter int PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_enable_i,
    input  logic               cfg_one_shot_i,
    input  logic               cfg_presc_en_i,
    input  logic [PRESC_W-1:0] cfg_presc_val_i,
    input  logic               cfg_irq_en_i,
    input  logic               clear_i,
    input  logic               irq_ack_i,
    input  logic               target_reached_i,
    output logic               reset_count_o,
    output logic               enable_count_o,
    output logic               irq_o,
    output logic               irq_pending_o,
    output logic               running_o,
    output logic [1:0]         dbg_state_o
);

    // Encoding is visible on dbg_state_o: 0 = IDLE, 1 = RUN, 2 = DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic               reset_count_q, reset_count_d;
    logic               enable_count_q, enable_count_d;
    logic               irq_q, irq_d;
    logic               irq_pending_q, irq_pending_d;
    logic               event_w;
    logic               reload_w;
    logic               tick_w;

    // An increment that is being overridden by a counter clear does not count as an event.
    assign event_w  = target_reached_i & enable_count_q & ~reset_count_q;
    assign reload_w = clear_i | (event_w & ~cfg_one_shot_i);

    always_comb begin
        state_d = state_q;
        if (!clear_i) begin
            case (state_q)
                IDLE: begin
                    if (cfg_enable_i) state_d = RUN;
                end
                RUN: begin
                    if (!cfg_enable_i)                 state_d = IDLE;
                    else if (event_w && cfg_one_shot_i) state_d = DONE;
                end
                DONE: begin
                    if (!cfg_enable_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // >= rather than == so that lowering the period mid-count reloads at once.
    always_comb begin
        presc_cnt_d = presc_cnt_q;
        tick_w      = 1'b0;
        if (reload_w) begin
            presc_cnt_d = '0;
        end else if (state_q == RUN) begin
            if (presc_cnt_q >= cfg_presc_val_i) begin
                presc_cnt_d = '0;
                tick_w      = 1'b1;
            end else begin
                presc_cnt_d = presc_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        enable_count_d = (state_q == RUN) && (state_d == RUN) && !reload_w &&
                         (!cfg_presc_en_i || tick_w);
        reset_count_d  = reload_w;
        irq_d          = event_w & cfg_irq_en_i;
        // Sticky flag: a new interrupt wins over a same-cycle irq_ack_i.
        if (irq_d)          irq_pending_d = 1'b1;
        else if (irq_ack_i) irq_pending_d = 1'b0;
        else                irq_pending_d = irq_pending_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            presc_cnt_q    <= '0;
            reset_count_q  <= 1'b0;
            enable_count_q <= 1'b0;
            irq_q          <= 1'b0;
            irq_pending_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_cnt_q    <= presc_cnt_d;
            reset_count_q  <= reset_count_d;
            enable_count_q <= enable_count_d;
            irq_q          <= irq_d;
            irq_pending_q  <= irq_pending_d;
        end
    end

    assign reset_count_o  = reset_count_q;
    assign enable_count_o = enable_count_q;
    assign irq_o          = irq_q;
    assign irq_pending_o  = irq_pending_q;
    assign running_o      = (state_q == RUN);
    assign dbg_state_o    = state_q;

endmodule
